pg_domain_scheduler: RTL
========================

Name: pg_domain_scheduler

Overview:
Central power-gating scheduler for N_DOM gated domains. Each domain has its own power-gating/clock-gating sequencing FSM. The scheduler drives that FSM's enable input from domain activity and an idle timeout. It monitors the FSM's en_iso/en_pw_sw outputs to detect completion, and lets only one domain transition at a time to limit inrush current.

Parameters:
N_DOM, 4, number of gated domains (2..8)
IDLE_W, 8, idle counter width
IDLE_TH, 100, consecutive idle cycles before a domain is put to sleep (less than 2^IDLE_W)
TMO, 15, max cycles to wait for transition completion before flagging an error
GAP, 2, dead cycles enforced between the end of one transition and the next grant

Ports:
ck  in  1  clock
rst  in  1  reset, asynchronous, active-high
act  in  N_DOM  per-domain activity/request; level, sampled on posedge ck
dom_iso  in  N_DOM  per-domain FSM en_iso feedback
dom_pw_sw  in  N_DOM  per-domain FSM en_pw_sw feedback
dom_en  out  N_DOM  per-domain FSM en input; 1 = keep/turn on, 0 = power down
dom_on  out  N_DOM  1 = domain fully on and usable
busy  out  1  a transition is in progress or the GAP timer is running
err  out  1  sticky timeout flag
err_id  out  3  index of the first domain that timed out

Behaviour:
- Reset values:
  - dom_en = all 1; dom_on = all 1; busy = 0; err = 0; err_id = 0.
  - Per-domain status = ON; idle counters = 0; rr pointer = 0; error mask = 0.
  - This matches the domain FSMs, which reset to their idle-on state.
- Per-domain status: ON, OFF, WAKING, SLEEPING. dom_on[i] = (status == ON), registered.
- Idle counter i:
  - Cleared when act[i] = 1 or status != ON.
  - Otherwise increments, saturating at IDLE_TH.
- Candidates are computed on unmasked domains only:
  - Wake candidate: status OFF and act[i] = 1.
  - Sleep candidate: status ON, idle counter == IDLE_TH, and act[i] = 0.
- Scheduler FSM states: S_IDLE, S_WAIT, S_GAP.
- S_IDLE:
  - If any wake candidate exists, grant one round-robin starting at the rr pointer. Wake has priority over sleep.
  - Otherwise, if any sleep candidate exists, grant the lowest index.
  - On grant: toggle dom_en[i] (wake sets 1, sleep sets 0), set status WAKING or SLEEPING, load the timer with 0, move to S_WAIT.
  - After a wake grant, rr pointer = i + 1, modulo N_DOM.
  - Grant is registered: dom_en changes on the edge after the candidate is visible.
- S_WAIT:
  - The timer increments each cycle.
  - Wake completes when dom_iso[i] == 0; then status ON.
  - Sleep completes when dom_pw_sw[i] == 0; then status OFF.
  - On completion, go to S_GAP with the timer cleared.
  - Nominal completion with a standard domain FSM is 5 cycles after dom_en changes.
- Timeout: if the timer reaches TMO without completion:
  - If err was 0, set err = 1 and err_id = i. Only the first timeout is recorded.
  - Set mask[i] = 1 and status OFF. dom_en[i] keeps its commanded value. Go to S_GAP.
  - A masked domain is never scheduled again until rst.
- S_GAP: wait GAP cycles, then return to S_IDLE. With GAP = 0, go straight to S_IDLE.
- busy = 1 in S_WAIT and S_GAP.
- No abort:
  - Activity on a SLEEPING domain does not reassert dom_en[i] until the sleep completes. The domain then becomes a wake candidate in S_IDLE.
  - A WAKING domain always completes its wake. Its idle counter starts only once it is ON.
- act on a domain that is ON only clears its idle counter; no transition occurs.
- At most one dom_en bit changes per transition window. dom_en never glitches: it is driven from flops.
- Reset mid-transition: everything returns to reset values at once, and dom_en returns to all 1.

Optional Feature:
PG_FORCE_ON_EN
- Defined:
  - Adds input port force_on (1 bit).
  - While force_on = 1: sleep candidates are suppressed, idle counters are held at 0, and every unmasked OFF domain is a wake candidate whatever its act value. Wakes are still serialized by the round-robin and GAP rules.
  - An in-progress sleep completes first; that domain is then woken.
- Undefined: the force_on port does not exist and behaviour is as above.

Test Plan:
1. Reset, all act = 0, IDLE_TH = 100, GAP = 2, FSM models attached -> after reset dom_en = 4'b1111 and dom_on = 4'b1111. Idle counters hit IDLE_TH at cycle 100; domain 0 is granted first (dom_en = 4'b1110), then domains 1, 2 and 3 sleep in turn, each about 5 + 2 cycles apart; finally dom_on = 4'b0000.
2. All domains OFF; act = 4'b0110 asserted in the same cycle -> domain 1 wakes first, dom_en[2] stays 0 until domain 1's dom_iso falls plus 2 GAP cycles, then domain 2 wakes. rr pointer ends at 3.
3. Domain 0 SLEEPING (dom_en[0] = 0); act[0] pulses 1 at cycle 2 of the sleep -> dom_en[0] stays 0 until dom_pw_sw[0] = 0. The domain wakes only if act[0] = 1 in S_IDLE.
4. Domain 3 granted wake with dom_iso[3] held at 1 -> after TMO = 15 cycles: err = 1, err_id = 3, busy drops after GAP. Further act[3] never toggles dom_en[3]. A later timeout on domain 1 leaves err_id = 3.
5. Domain 2 ON, act[2] toggling with gaps of 99 cycles -> no sleep. A gap of 100 cycles -> dom_en[2] falls on the next edge.
6. PG_FORCE_ON_EN defined, all OFF, force_on = 1, act = 0 -> domains wake in order 0, 1, 2, 3. No sleep occurs while force_on stays high, even after more than 100 idle cycles.

Source files
------------

// File: rtl/pg_domain_scheduler.sv
// pg_domain_scheduler: central power-gating scheduler for N_DOM gated domains.
// Drives each domain FSM's enable from activity and an idle timeout, watches the
// FSM's en_iso / en_pw_sw feedback for completion, and serializes transitions
// (one at a time, GAP dead cycles between) to limit inrush current.
//
// Ports:
//   ck, rst     clock, asynchronous active-high reset
//   act         per-domain activity / request (level)
//   dom_iso     per-domain FSM en_iso feedback (wake done when it falls)
//   dom_pw_sw   per-domain FSM en_pw_sw feedback (sleep done when it falls)
//   force_on    only when PG_FORCE_ON_EN is defined: wake every unmasked domain
//   dom_en      per-domain FSM enable, 1 = keep/turn on
//   dom_on      per-domain fully-on status
//   busy        transition in progress or GAP timer running
//   err, err_id sticky timeout flag and index of the first domain that timed out
//
// Build option: define PG_FORCE_ON_EN to add the force_on input.
module pg_domain_scheduler #(
   parameter int unsigned N_DOM   = 4,
   parameter int unsigned IDLE_W  = 8,
   parameter int unsigned IDLE_TH = 100,
   parameter int unsigned TMO     = 15,
   parameter int unsigned GAP     = 2
) (
   input  logic             ck,
   input  logic             rst,
   input  logic [N_DOM-1:0] act,
   input  logic [N_DOM-1:0] dom_iso,
   input  logic [N_DOM-1:0] dom_pw_sw,
`ifdef PG_FORCE_ON_EN
   input  logic             force_on,
`endif
   output logic [N_DOM-1:0] dom_en,
   output logic [N_DOM-1:0] dom_on,
   output logic             busy,
   output logic             err,
   output logic [2:0]       err_id
);

   localparam int unsigned TMax = (TMO > GAP) ? TMO : GAP;
   localparam int unsigned TW   = (TMax < 2) ? 1 : $clog2(TMax + 1);
   localparam int unsigned PW   = (N_DOM < 2) ? 1 : $clog2(N_DOM);

   typedef enum logic [1:0] {DomOn, DomOff, DomWaking, DomSleeping} dom_st_e;
   typedef enum logic [1:0] {StIdle, StWait, StGap} sched_st_e;

   sched_st_e         state_q, state_d;
   dom_st_e           status_q [N_DOM];
   dom_st_e           status_d [N_DOM];
   logic [IDLE_W-1:0] idle_q [N_DOM];
   logic [IDLE_W-1:0] idle_d [N_DOM];
   logic [N_DOM-1:0]  dom_en_q, dom_en_d, dom_on_q, dom_on_d, mask_q, mask_d;
   logic [PW-1:0]     rr_q, rr_d, cur_q, cur_d;
   logic              wake_q, wake_d, err_q, err_d;
   logic [2:0]        err_id_q, err_id_d;
   logic [TW-1:0]     timer_q, timer_d;

   logic              force_w;
   logic [N_DOM-1:0]  wake_cand, sleep_cand;
   logic              wake_found, sleep_found;
   logic [PW-1:0]     wake_idx, sleep_idx, jj;

`ifdef PG_FORCE_ON_EN
   assign force_w = force_on;
`else
   assign force_w = 1'b0;
`endif

   // Candidate selection: round-robin for wakes, lowest index for sleeps.
   always_comb begin
      wake_cand   = '0;
      sleep_cand  = '0;
      wake_found  = 1'b0;
      wake_idx    = '0;
      sleep_found = 1'b0;
      sleep_idx   = '0;
      jj          = '0;
      for (int unsigned i = 0; i < N_DOM; i++) begin
         wake_cand[i]  = !mask_q[i] && (status_q[i] == DomOff) && (act[i] || force_w);
         sleep_cand[i] = !mask_q[i] && !force_w && (status_q[i] == DomOn) &&
                         (idle_q[i] == IDLE_W'(IDLE_TH)) && !act[i];
      end
      for (int unsigned k = 0; k < N_DOM; k++) begin
         jj = PW'((32'(rr_q) + k) % N_DOM);
         if (!wake_found && wake_cand[jj]) begin
            wake_found = 1'b1;
            wake_idx   = jj;
         end
      end
      for (int unsigned k = 0; k < N_DOM; k++) begin
         if (!sleep_found && sleep_cand[k]) begin
            sleep_found = 1'b1;
            sleep_idx   = PW'(k);
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      dom_en_d = dom_en_q;
      mask_d   = mask_q;
      rr_d     = rr_q;
      cur_d    = cur_q;
      wake_d   = wake_q;
      timer_d  = timer_q;
      err_d    = err_q;
      err_id_d = err_id_q;
      for (int unsigned i = 0; i < N_DOM; i++) begin
         status_d[i] = status_q[i];
         if (act[i] || force_w || (status_q[i] != DomOn)) begin
            idle_d[i] = '0;
         end else if (idle_q[i] == IDLE_W'(IDLE_TH)) begin
            idle_d[i] = idle_q[i];
         end else begin
            idle_d[i] = idle_q[i] + 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (wake_found) begin
               dom_en_d[wake_idx] = 1'b1;
               status_d[wake_idx] = DomWaking;
               cur_d   = wake_idx;
               wake_d  = 1'b1;
               rr_d    = (wake_idx == PW'(N_DOM - 1)) ? '0 : wake_idx + 1'b1;
               timer_d = '0;
               state_d = StWait;
            end else if (sleep_found) begin
               dom_en_d[sleep_idx] = 1'b0;
               status_d[sleep_idx] = DomSleeping;
               cur_d   = sleep_idx;
               wake_d  = 1'b0;
               timer_d = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            timer_d = timer_q + 1'b1;
            if (wake_q ? !dom_iso[cur_q] : !dom_pw_sw[cur_q]) begin
               status_d[cur_q] = wake_q ? DomOn : DomOff;
               timer_d = '0;
               state_d = (GAP == 0) ? StIdle : StGap;
            end else if (timer_q == TW'(TMO - 1)) begin
               // Give up on this domain for good; dom_en keeps its commanded value.
               if (!err_q) begin
                  err_d    = 1'b1;
                  err_id_d = 3'(cur_q);
               end
               mask_d[cur_q]   = 1'b1;
               status_d[cur_q] = DomOff;
               timer_d = '0;
               state_d = (GAP == 0) ? StIdle : StGap;
            end
         end
         StGap: begin
            if (timer_q == TW'(GAP - 1)) begin
               timer_d = '0;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      for (int unsigned i = 0; i < N_DOM; i++) begin
         dom_on_d[i] = (status_d[i] == DomOn);
      end
   end

   // State registers.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         dom_en_q <= '1;
         dom_on_q <= '1;
         mask_q   <= '0;
         rr_q     <= '0;
         cur_q    <= '0;
         wake_q   <= 1'b0;
         timer_q  <= '0;
         err_q    <= 1'b0;
         err_id_q <= '0;
         for (int unsigned i = 0; i < N_DOM; i++) begin
            status_q[i] <= DomOn;
            idle_q[i]   <= '0;
         end
      end else begin
         state_q  <= state_d;
         dom_en_q <= dom_en_d;
         dom_on_q <= dom_on_d;
         mask_q   <= mask_d;
         rr_q     <= rr_d;
         cur_q    <= cur_d;
         wake_q   <= wake_d;
         timer_q  <= timer_d;
         err_q    <= err_d;
         err_id_q <= err_id_d;
         for (int unsigned i = 0; i < N_DOM; i++) begin
            status_q[i] <= status_d[i];
            idle_q[i]   <= idle_d[i];
         end
      end
   end

   // Outputs.
   always_comb begin
      busy   = (state_q != StIdle);
      dom_en = dom_en_q;
      dom_on = dom_on_q;
      err    = err_q;
      err_id = err_id_q;
   end

endmodule
